// File: rtl/ygr019_data_fifo_if.sv
// ygr019_data_fifo_if
//   Bundles the FIFO's control strobes, the host and CD-side data ports, the
//   transfer-counter controls and the DATASTAT status outputs.
//   slave  : the FIFO itself (takes strobes and data, drives DO and status)
//   master : the surrounding logic (drives strobes and data, observes DO and status)
interface ygr019_data_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic                  DIR_SET;
  logic                  DIR_IN;
  logic                  FLUSH;
  logic                  HOST_WR;
  logic                  HOST_RD;
  logic [15:0]           HOST_DI;
  logic [15:0]           HOST_DO;
  logic                  CD_WR;
  logic                  CD_RD;
  logic [15:0]           CD_DI;
  logic [15:0]           CD_DO;
  logic                  TC_LOAD;
  logic [17:0]           TC_VAL;
  logic                  EMP;
  logic                  FUL;
  logic                  DIR;
  logic [DEPTH_LOG2:0]   LEVEL;
  logic                  TC_BUSY;
  logic                  TC_DONE;
  logic                  OVF;

  modport slave (
    input  DIR_SET, DIR_IN, FLUSH,
    input  HOST_WR, HOST_RD, HOST_DI,
    input  CD_WR, CD_RD, CD_DI,
    input  TC_LOAD, TC_VAL,
    output HOST_DO, CD_DO,
    output EMP, FUL, DIR, LEVEL, TC_BUSY, TC_DONE, OVF
  );

  modport master (
    output DIR_SET, DIR_IN, FLUSH,
    output HOST_WR, HOST_RD, HOST_DI,
    output CD_WR, CD_RD, CD_DI,
    output TC_LOAD, TC_VAL,
    input  HOST_DO, CD_DO,
    input  EMP, FUL, DIR, LEVEL, TC_BUSY, TC_DONE, OVF
  );
endinterface

// File: rtl/ygr019_data_fifo.sv
// ygr019_data_fifo
//   16-bit word FIFO behind the CD block host data window. The direction bit
//   selects which side pushes and which side pops; the FIFO reports EMP/FUL/DIR
//   status and runs an 18-bit transfer counter that pulses TC_DONE when the
//   last host-side word of a transfer has been accepted.
// Ports
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : ygr019_data_fifo_if.slave (strobes, data, counter load, status)
module ygr019_data_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  ygr019_data_fifo_if.slave     bus
);

  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [15:0]           mem_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q,  level_d;
  logic                  dir_q,    dir_d;
  logic [17:0]           tc_q,     tc_d;
  logic                  tc_done_q, tc_done_d;
  logic                  ovf_q,    ovf_d;

  logic                  emp, ful;
  logic                  push_req, pop_req;
  logic                  push_ok, pop_ok, host_acc;
  logic [15:0]           push_data;
  logic                  mem_we;
  logic [15:0]           head;

  always_comb begin
    emp       = (level_q == '0);
    ful       = (level_q == LVL_FULL);
    push_req  = dir_q ? bus.HOST_WR : bus.CD_WR;
    push_data = dir_q ? bus.HOST_DI : bus.CD_DI;
    pop_req   = dir_q ? bus.CD_RD   : bus.HOST_RD;
    // Acceptance is judged on pre-edge state: a simultaneous pop does not make
    // room for a push into a full FIFO, and vice versa for an empty one.
    push_ok   = push_req & ~ful;
    pop_ok    = pop_req  & ~emp;
    host_acc  = dir_q ? push_ok : pop_ok;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    dir_d     = dir_q;
    tc_d      = tc_q;
    tc_done_d = 1'b0;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;

    if (bus.FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      tc_d     = '0;
      ovf_d    = 1'b0;
    end else if (bus.DIR_SET) begin
      dir_d    = bus.DIR_IN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        level_d = level_q + LVL_ONE;
      end else if (pop_ok && !push_ok) begin
        level_d = level_q - LVL_ONE;
      end
      if ((push_req && ful) || (pop_req && emp)) begin
        ovf_d = 1'b1;
      end
      // A load in the same cycle as a host access replaces the count; the
      // access still moves data but does not consume from the new count.
      if (bus.TC_LOAD) begin
        tc_d = bus.TC_VAL;
      end else if (host_acc && (tc_q != '0)) begin
        tc_d      = tc_q - 18'd1;
        tc_done_d = (tc_q == 18'd1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dir_q     <= 1'b0;
      tc_q      <= '0;
      tc_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      dir_q     <= dir_d;
      tc_q      <= tc_d;
      tc_done_q <= tc_done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset; unwritten entries are never visible because the
  // head outputs are forced to all-ones while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    bus.HOST_DO = (!dir_q && !emp) ? head : '1;
    bus.CD_DO   = ( dir_q && !emp) ? head : '1;
    bus.EMP     = emp;
    bus.FUL     = ful;
    bus.DIR     = dir_q;
    bus.LEVEL   = level_q;
    bus.TC_BUSY = (tc_q != '0);
    bus.TC_DONE = tc_done_q;
    bus.OVF     = ovf_q;
  end

endmodule
